// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM pipeline stage.
package mem_stage_pkg;
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int         TIMEOUT_DEF = 16;
   localparam logic [3:0] REG_ZERO    = 4'h0;
endpackage

// File: rtl/Register.sv
// Multi-bit enabled register, async active-high clear.
module Register #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      q <= '0;
      else if (wen) q <= d;
   end
endmodule

// File: rtl/dff.sv
// Single-bit enabled flop, async active-high clear.
module dff (
   input  logic clk,
   input  logic rst,
   input  logic wen,
   input  logic d,
   output logic q
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      q <= 1'b0;
      else if (wen) q <= d;
   end
endmodule

// File: rtl/mem_stage_wb_store_fwd.sv
// Store-data bypass from the WB stage; r0 is never a forwarding source.
module wb_store_fwd
   import mem_stage_pkg::*;
(
   input  logic        wb_RegWrite,
   input  logic [3:0]  wb_wreg,
   input  logic [15:0] wb_data,
   input  logic [3:0]  st_reg,
   input  logic [15:0] st_data,
   output logic [15:0] fwd_data
);
   logic hit;

   assign hit      = wb_RegWrite && (wb_wreg == st_reg) && (wb_wreg != REG_ZERO);
   assign fwd_data = hit ? wb_data : st_data;
endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues a memory access, stalls upstream until the response or
// a watchdog timeout, and hands results plus control to the MEM/WB latch.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        MemtoReg_in,
   input  logic        RegWrite_in,
   input  logic        PCS_in,
   input  logic [3:0]  wreg_in,
   input  logic [3:0]  st_reg_in,
   input  logic [15:0] alu_in,
   input  logic [15:0] st_data_in,
   input  logic [15:0] npc_in,
   input  logic        wb_RegWrite,
   input  logic [3:0]  wb_wreg,
   input  logic [15:0] wb_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_valid,
   output logic        mem_stall,
   output logic        mem_err,
   output logic        MemtoReg_out,
   output logic        RegWrite_out,
   output logic        PCS_out,
   output logic [3:0]  wreg_out,
   output logic [15:0] npc_out,
   output logic [15:0] alu_out,
   output logic [15:0] mem_out
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic             mem_op;
   logic [15:0]      fwd_data;
   logic             state_q;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             cap;
   logic             hold_we;
   logic [15:0]      hold_addr, hold_wdata;

   assign mem_op = MemRead_in | MemWrite_in;
   assign state  = state_t'(state_q);

   wb_store_fwd u_fwd (
      .wb_RegWrite (wb_RegWrite),
      .wb_wreg     (wb_wreg),
      .wb_data     (wb_data),
      .st_reg      (st_reg_in),
      .st_data     (st_data_in),
      .fwd_data    (fwd_data)
   );

   dff u_state (.clk(clk), .rst(rst), .wen(1'b1), .d(logic'(state_nxt)), .q(state_q));

   Register #(.WIDTH(CNT_W)) u_cnt (.clk(clk), .rst(rst), .wen(1'b1), .d(cnt_nxt), .q(cnt));

   // Request attributes are latched once at issue and replayed for the whole wait.
   dff u_hold_we (.clk(clk), .rst(rst), .wen(cap), .d(MemWrite_in), .q(hold_we));

   Register #(.WIDTH(16)) u_hold_addr (.clk(clk), .rst(rst), .wen(cap), .d(alu_in), .q(hold_addr));

   Register #(.WIDTH(16)) u_hold_wdata (.clk(clk), .rst(rst), .wen(cap), .d(fwd_data), .q(hold_wdata));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cap       = 1'b0;
      mem_req   = 1'b0;
      mem_stall = 1'b0;
      mem_err   = 1'b0;
      mem_out   = 16'h0000;
      mem_we    = 1'b0;
      mem_addr  = alu_in;
      mem_wdata = fwd_data;
      case (state)
         IDLE: begin
            // A late mem_valid here belongs to an access killed by reset.
            if (mem_op) begin
               mem_req   = 1'b1;
               mem_we    = MemWrite_in;
               mem_stall = 1'b1;
               cap       = 1'b1;
               cnt_nxt   = '0;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            mem_we    = hold_we;
            mem_addr  = hold_addr;
            mem_wdata = hold_wdata;
            if (mem_valid) begin
               if (!hold_we) mem_out = mem_rdata;
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               mem_err   = 1'b1;
               state_nxt = IDLE;
            end else begin
               // Leaves before reaching CNT_LAST+1, so it can never wrap.
               mem_stall = 1'b1;
               cnt_nxt   = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (rst) begin
         mem_req   = 1'b0;
         mem_stall = 1'b0;
         mem_err   = 1'b0;
         mem_out   = 16'h0000;
      end
   end

   // Stalled cycles become bubbles; an aborted access must not write back.
   assign RegWrite_out = RegWrite_in & ~mem_stall & ~mem_err;
   assign MemtoReg_out = MemtoReg_in & ~mem_stall;
   assign PCS_out      = PCS_in;
   assign wreg_out     = wreg_in;
   assign npc_out      = npc_in;
   assign alu_out      = alu_in;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage between the EX/MEM latch and the MEM/WB latch.
- Drives a variable-latency data memory with a req/valid handshake.
- Forwards WB-stage data into store data.
- Stalls the front of the pipeline while an access is outstanding, and presents read data plus pass-through control to the MEM/WB latch.
- A watchdog aborts accesses that never complete.

Parameters:
- TIMEOUT, 16, max WAIT cycles before abort (≥2).
- CNT_W, 5, watchdog counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- MemRead_in  in  1  load in MEM.
- MemWrite_in  in  1  store in MEM.
- MemtoReg_in, RegWrite_in, PCS_in  in  1 each  EX/MEM control.
- wreg_in  in  4  destination reg.
- st_reg_in  in  4  store source reg number.
- alu_in  in  16  address / ALU result.
- st_data_in  in  16  store data from EX/MEM.
- npc_in  in  16  next PC.
- wb_RegWrite  in  1  WB stage writes.
- wb_wreg  in  4  WB destination.
- wb_data  in  16  WB write data.
- mem_req  out  1  memory request pulse.
- mem_we  out  1  write request.
- mem_addr  out  16  held address.
- mem_wdata  out  16  held write data.
- mem_rdata  in  16  read data.
- mem_valid  in  1  access complete.
- mem_stall  out  1  freeze PC/IF-ID/ID-EX/EX-MEM.
- mem_err  out  1  timeout pulse.
- MemtoReg_out, RegWrite_out, PCS_out  out  1 each  to MEM/WB.
- wreg_out  out  4  to MEM/WB.
- npc_out, alu_out  out  16  to MEM/WB.
- mem_out  out  16  load data to MEM/WB.

Behaviour:
- Interface: one clock clk; rst is asynchronous, active-high. All state registers clear immediately on rst.
- Reset values:
  - state = IDLE, watchdog cnt = 0.
  - Held address and held write data = 0; held we = 0.
  - mem_req = 0, mem_stall = 0, mem_err = 0.
- Forwarding: fwd_data = wb_data when wb_RegWrite & (wb_wreg == st_reg_in) & (wb_wreg != 0); otherwise st_data_in. Applies only to stores.
- States: IDLE, WAIT.
- IDLE:
  - If MemRead_in | MemWrite_in: mem_req = 1 combinationally.
    - mem_we = MemWrite_in, mem_addr = alu_in, mem_wdata = fwd_data, all driven combinationally.
    - Same values are registered at the edge; go to WAIT; cnt = 0.
    - mem_stall = 1.
  - Otherwise: mem_req = 0, mem_stall = 0. Controls pass straight through.
  - mem_valid in IDLE is ignored (stale response after reset).
  - MemRead_in & MemWrite_in together is treated as a write.
- WAIT:
  - mem_req = 0. mem_we, mem_addr and mem_wdata come from the held registers and stay stable.
  - mem_valid = 1:
    - mem_stall = 0; mem_out = mem_rdata (combinational pass-through).
    - Return to IDLE.
    - The MEM/WB latch captures the access at this edge, and upstream advances at the same edge. Latency = request cycle + response cycles.
  - mem_valid = 0 and cnt == TIMEOUT-1:
    - mem_err = 1 for exactly one cycle; mem_stall = 0; mem_out = 16'h0000.
    - RegWrite_out forced to 0; return to IDLE.
  - Otherwise: cnt increments; mem_stall = 1.
- Bubble insertion: while mem_stall = 1, RegWrite_out = 0 and MemtoReg_out = 0. MEM/WB therefore receives a bubble each stalled cycle. All other outputs pass through unchanged (EX/MEM is frozen).
- mem_out outside a completing read = 16'h0000.
- alu_out, npc_out, wreg_out and PCS_out are pure pass-through.
- Back-to-back memory ops: the completing cycle returns to IDLE. The next op issues its mem_req in the following cycle, so there is no request on the completing cycle itself.
- Reset mid-WAIT: drop to IDLE at once; mem_req = 0; a later mem_valid is ignored.
- Watchdog counter saturates and never wraps; it is cleared on every IDLE→WAIT transition.

Decomposition:
- Shared package constants:
  - State encoding: IDLE = 1'b0, WAIT = 1'b1.
  - Default TIMEOUT.
  - Register-zero index 4'h0.
- State and hold registers are built from the existing dff and Register cells, with wen tied to capture conditions.
- One sub-module: wb_store_fwd, the combinational forward compare/mux.

Test Plan:
- Load, 3-cycle memory:
  - Stimulus: MemRead_in = 1, alu_in = 16'h0040; mem_valid on the 3rd cycle after req with rdata = 16'hBEEF.
  - Response: mem_req pulses once; mem_stall = 1 for 3 cycles; on the valid cycle mem_out = BEEF, RegWrite_out = 1, stall = 0.
- Store with WB forward:
  - Stimulus: st_reg_in = 4'h3, wb_RegWrite = 1, wb_wreg = 3, wb_data = 16'h1234, st_data_in = 16'h0000.
  - Response: mem_we = 1, mem_wdata = 1234 held until valid.
  - Repeat with wb_wreg = 0 → mem_wdata = 0000.
- Timeout, TIMEOUT = 16:
  - Stimulus: load with no mem_valid.
  - Response: stall for 16 cycles; mem_err pulses for 1 cycle; RegWrite_out = 0; state returns to IDLE.
- Reset mid-WAIT:
  - Stimulus: assert rst 2 cycles into WAIT; then mem_valid arrives after rst drops.
  - Response: stall = 0 and mem_req = 0 immediately; the late valid is ignored; mem_out = 0.
- Back-to-back loads, 1-cycle memory:
  - Stimulus: two consecutive loads.
  - Response: req, valid, req, valid. Each completion drives mem_out correctly, with exactly one bubble per load.
- Non-memory op:
  - Stimulus: RegWrite_in = 1, alu_in = 16'h00FF.
  - Response: zero-cycle pass-through; alu_out = 00FF; mem_stall never asserted.
